game_credit_ctrl: RTL and testbench

Sequences the credit and game-start flow for the start-screen subsystem. Accepts debounced coin pulses and player start requests, keeps the credit count (0..MAX_CREDITS), and runs the standby → start-delay → playing → game-over cycle. Emits the one-cycle `startGame` pulse and the `standBy` level consumed by the credit display and the start-screen overlays. Sits between the button debouncers and the credit display / game-core blocks, and is the single owner of the credit count.

---
 rtl/game_credit_ctrl_pkg.sv | 33 +++
 rtl/game_credit_ctrl_frame_down_counter.sv | 25 ++
 rtl/game_credit_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_credit_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_credit_ctrl_pkg.sv
// Shared types and constants for the start-screen credit controller.
// Holds the state enum, credit width and default frame timings.
package game_credit_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READY,
      STARTING,
      PLAYING,
      GAME_OVER
   } credit_state_t;

   localparam int CREDIT_W = 4;

   localparam int DEF_MAX_CREDITS = 4;
   localparam int DEF_START_DELAY = 60;
   localparam int DEF_OVER_HOLD   = 180;
   localparam int DEF_BLINK       = 30;

   // Width that holds the largest of three frame counts without wrap.
   function automatic int frameWidth(
      input int a,
      input int b,
      input int c
   );
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/game_credit_ctrl_frame_down_counter.sv
// Loadable frame down-counter; decrements on frame ticks.
// done is high while the count sits at zero.
module frame_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         load,
   input  logic [W-1:0] loadValue,
   input  logic         frameTick,
   output logic         done
);

   logic [W-1:0] count;

   // Load has priority; otherwise count ticks down and rest at zero.
   always_ff @(posedge clk) begin
      if (load)
         count <= loadValue;
      else if (frameTick && count != '0)
         count <= count - W'(1);
   end

   assign done = (count == '0);

endmodule

// File: rtl/game_credit_ctrl.sv
// Credit and game-start sequencer for the start screen.
// Owns the credit count and the standby/start/play/over cycle.
module game_credit_ctrl
   import game_credit_ctrl_pkg::*;
#(
   parameter int MAX_CREDITS        = DEF_MAX_CREDITS,
   parameter int START_DELAY_FRAMES = DEF_START_DELAY,
   parameter int OVER_HOLD_FRAMES   = DEF_OVER_HOLD,
   parameter int BLINK_FRAMES       = DEF_BLINK
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frameTick,
   input  logic                coinPulse,
   input  logic                startReq,
   input  logic                gameOver,
   output logic [CREDIT_W-1:0] credits,
   output logic                startGame,
   output logic                standBy,
   output logic                playing,
   output logic                blinkOn,
   output logic                coinReject
);

   localparam int FRAME_W = frameWidth(
      START_DELAY_FRAMES, OVER_HOLD_FRAMES, BLINK_FRAMES);
   localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);

   credit_state_t       state;
   credit_state_t       nextState;
   logic [CREDIT_W-1:0] creditsNext;
   logic                startTake;
   logic                coinRejectNext;
   logic                startGameNext;
   logic                entering;
   logic                standByNext;
   logic                delayDone;
   logic                blinkDone;
   logic                delayExpire;
   logic                blinkExpire;
   logic                delayLoad;
   logic                blinkLoad;
   logic [FRAME_W-1:0]  delayLoadValue;

   assign delayExpire = frameTick & delayDone;
   assign blinkExpire = frameTick & blinkDone;
   assign entering    = (nextState != state);
   assign standByNext = (nextState == IDLE) || (nextState == READY);

   // Credit arithmetic: a taken start absorbs a same-cycle coin.
   always_comb begin
      startTake      = (state == READY) && startReq && (credits != '0);
      creditsNext    = credits;
      coinRejectNext = 1'b0;
      if (startTake) begin
         if (!coinPulse)
            creditsNext = credits - CREDIT_W'(1);
      end else if (coinPulse) begin
         if (credits == MAX_C)
            coinRejectNext = 1'b1;
         else
            creditsNext = credits + CREDIT_W'(1);
      end
   end

   // Next-state decode and the startGame launch pulse.
   always_comb begin
      nextState     = state;
      startGameNext = 1'b0;
      unique case (state)
         IDLE:
            if (creditsNext != '0)
               nextState = READY;
         READY:
            if (startTake)
               nextState = STARTING;
         STARTING:
            if (delayExpire) begin
               nextState     = PLAYING;
               startGameNext = 1'b1;
            end
         PLAYING:
            if (gameOver)
               nextState = GAME_OVER;
         GAME_OVER:
            if (delayExpire)
               nextState = (creditsNext != '0) ? READY : IDLE;
         default:
            nextState = IDLE;
      endcase
   end

   // Delay/hold timer reloads on every state entry; N-1 gives the Nth tick.
   always_comb begin
      delayLoadValue = '0;
      if (!reset) begin
         if (nextState == STARTING)
            delayLoadValue = FRAME_W'(START_DELAY_FRAMES - 1);
         else if (nextState == GAME_OVER)
            delayLoadValue = FRAME_W'(OVER_HOLD_FRAMES - 1);
      end
   end

   assign delayLoad = reset | entering;
   assign blinkLoad = reset | entering | blinkExpire;

   frame_down_counter #(.W(FRAME_W)) delayTimer (
      .clk       (clk),
      .load      (delayLoad),
      .loadValue (delayLoadValue),
      .frameTick (frameTick),
      .done      (delayDone)
   );

   frame_down_counter #(.W(FRAME_W)) blinkTimer (
      .clk       (clk),
      .load      (blinkLoad),
      .loadValue (FRAME_W'(BLINK_FRAMES - 1)),
      .frameTick (frameTick),
      .done      (blinkDone)
   );

   // State, credit and pulse output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         credits    <= '0;
         startGame  <= 1'b0;
         coinReject <= 1'b0;
         standBy    <= 1'b1;
         playing    <= 1'b0;
      end else begin
         state      <= nextState;
         credits    <= creditsNext;
         startGame  <= startGameNext;
         coinReject <= coinRejectNext;
         standBy    <= standByNext;
         playing    <= (nextState == PLAYING);
      end
   end

   // Blink restarts high on standby entry and toggles per blink period.
   always_ff @(posedge clk) begin
      if (reset)
         blinkOn <= 1'b1;
      else if (!standByNext)
         blinkOn <= 1'b0;
      else if (entering)
         blinkOn <= 1'b1;
      else if (blinkExpire)
         blinkOn <= ~blinkOn;
   end

endmodule

// File: tb/tb_game_credit_ctrl.sv
// Randomized bench for game_credit_ctrl against a tick-counting model.
// Directed test-plan scenarios run first, then random traffic.
module tb_game_credit_ctrl;
   import game_credit_ctrl_pkg::*;

   localparam int MAXC  = 4;
   localparam int DELAY = 60;
   localparam int HOLD  = 180;
   localparam int BLINK = 30;

   localparam int M_IDLE  = 0;
   localparam int M_READY = 1;
   localparam int M_START = 2;
   localparam int M_PLAY  = 3;
   localparam int M_OVER  = 4;

   logic          clk;
   logic          reset;
   logic          frameTick;
   logic          coinPulse;
   logic          startReq;
   logic          gameOver;
   logic [3:0]    credits;
   logic          startGame;
   logic          standBy;
   logic          playing;
   logic          blinkOn;
   logic          coinReject;

   int errCount;
   int chkCount;

   int mMode;
   int mCred;
   int mTicks;
   int mBlinkTicks;
   int mBlink;
   int mStartGame;
   int mReject;

   game_credit_ctrl #(
      .MAX_CREDITS        (MAXC),
      .START_DELAY_FRAMES (DELAY),
      .OVER_HOLD_FRAMES   (HOLD),
      .BLINK_FRAMES       (BLINK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frameTick  (frameTick),
      .coinPulse  (coinPulse),
      .startReq   (startReq),
      .gameOver   (gameOver),
      .credits    (credits),
      .startGame  (startGame),
      .standBy    (standBy),
      .playing    (playing),
      .blinkOn    (blinkOn),
      .coinReject (coinReject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      chkCount++;
      if (got != exp) begin
         errCount++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: counts ticks since entry, compares to limits.
   task automatic modelStep(input bit r, input bit c, input bit s,
                            input bit g, input bit t);
      int  newMode;
      bit  take;
      if (r) begin
         mMode = M_IDLE; mCred = 0; mTicks = 0; mBlinkTicks = 0;
         mBlink = 1; mStartGame = 0; mReject = 0;
         return;
      end
      take = (mMode == M_READY) && s && (mCred > 0);
      mReject = 0;
      mStartGame = 0;
      if (take) begin
         if (!c) mCred--;
      end else if (c) begin
         if (mCred == MAXC) mReject = 1;
         else mCred++;
      end
      newMode = mMode;
      case (mMode)
         M_IDLE:  if (mCred > 0) newMode = M_READY;
         M_READY: if (take) newMode = M_START;
         M_START: begin
            if (t) mTicks++;
            if (mTicks == DELAY) begin
               newMode = M_PLAY;
               mStartGame = 1;
            end
         end
         M_PLAY:  if (g) newMode = M_OVER;
         default: begin
            if (t) mTicks++;
            if (mTicks == HOLD)
               newMode = (mCred > 0) ? M_READY : M_IDLE;
         end
      endcase
      if (newMode == M_IDLE || newMode == M_READY) begin
         if (newMode != mMode) begin
            mBlink = 1;
            mBlinkTicks = 0;
         end else if (t) begin
            mBlinkTicks++;
            if (mBlinkTicks == BLINK) begin
               mBlink ^= 1;
               mBlinkTicks = 0;
            end
         end
      end else begin
         mBlink = 0;
      end
      if (newMode != mMode) mTicks = 0;
      mMode = newMode;
   endtask

   task automatic step(input bit r, input bit c, input bit s,
                       input bit g, input bit t);
      reset = r; coinPulse = c; startReq = s; gameOver = g; frameTick = t;
      @(posedge clk);
      modelStep(r, c, s, g, t);
      #1;
      chk("credits", int'(credits), mCred);
      chk("startGame", int'(startGame), mStartGame);
      chk("standBy", int'(standBy),
          int'(mMode == M_IDLE || mMode == M_READY));
      chk("playing", int'(playing), int'(mMode == M_PLAY));
      chk("blinkOn", int'(blinkOn), mBlink);
      chk("coinReject", int'(coinReject), mReject);
   endtask

   initial begin
      int expCred [5];
      expCred[0] = 1; expCred[1] = 2; expCred[2] = 3;
      expCred[3] = 4; expCred[4] = 4;
      errCount = 0; chkCount = 0;
      reset = 1'b0; coinPulse = 1'b0; startReq = 1'b0;
      gameOver = 1'b0; frameTick = 1'b0;
      modelStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      step(1, 0, 0, 0, 0);
      chk("rstCredits", int'(credits), 0);
      chk("rstStandBy", int'(standBy), 1);
      chk("rstBlink", int'(blinkOn), 1);

      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 0);
         chk("coinCredits", int'(credits), expCred[i]);
         chk("coinReject5", int'(coinReject), int'(i == 4));
      end
      step(0, 0, 0, 0, 0);
      chk("rejectOneCycle", int'(coinReject), 0);
      chk("readyStandBy", int'(standBy), 1);

      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("startCredits", int'(credits), 1);
      chk("startingStandBy", int'(standBy), 0);
      for (int i = 1; i <= DELAY; i++) begin
         step(0, 0, 1, 0, 1);
         chk("delayStartGame", int'(startGame), int'(i == DELAY));
      end
      chk("delayPlaying", int'(playing), 1);
      step(0, 0, 1, 0, 0);
      chk("startGamePulse", int'(startGame), 0);
      chk("playStartIgnored", int'(credits), 1);

      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < DELAY; i++) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0);
      chk("overPlaying", int'(playing), 0);
      for (int i = 0; i < HOLD; i++) step(0, 0, 0, 0, 1);
      chk("overIdleStandBy", int'(standBy), 1);
      chk("overIdleBlink", int'(blinkOn), 1);
      step(0, 0, 1, 0, 0);
      chk("idleStartIgnored", int'(standBy), 1);
      chk("idleStartCredits", int'(credits), 0);

      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("coinStartCredits", int'(credits), 1);
      chk("coinStartState", int'(standBy), 0);

      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("midStartCredits", int'(credits), 3);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      chk("midRstCredits", int'(credits), 0);
      chk("midRstStartGame", int'(startGame), 0);
      chk("midRstStandBy", int'(standBy), 1);

      for (int i = 0; i < 15000; i++) begin
         step($urandom_range(0, 799) == 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 2) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errCount, chkCount);
      $finish;
   end

endmodule
